// File: rtl/spi_slave_reg_ctrl_pkg.sv
// Shared definitions for the SPI register controller: FSM states,
// acknowledge nibbles, command byte field positions and command decode.
package spi_slave_reg_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_DATA = 2'd1,
      ST_RD_RESP = 2'd2
   } state_t;

   localparam logic [3:0] ACK_OK  = 4'hA;
   localparam logic [3:0] ACK_ERR = 4'hE;

   localparam int CMD_WR_BIT   = 7;
   localparam int CMD_RSV_MSB  = 6;
   localparam int CMD_RSV_LSB  = 4;
   localparam int CMD_ADDR_MSB = 3;
   localparam int CMD_ADDR_LSB = 0;

   // A command is usable only with clear reserved bits and an address inside the bank
   function automatic logic cmdIsValid(input logic [7:0] cmd, input int nregs);
      return (cmd[CMD_RSV_MSB:CMD_RSV_LSB] == 3'b000) &&
             (int'({28'd0, cmd[CMD_ADDR_MSB:CMD_ADDR_LSB]}) < nregs);
   endfunction

endpackage

// File: rtl/spi_slave_reg_ctrl_if.sv
// Bus between spi_slave/application logic and the register controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface spi_slave_reg_ctrl_if #(
   parameter int NREGS = 8,
   parameter int ERR_W = 8
);

   logic [7:0]         recv_data;
   logic               recv_rdy;
   logic [11:0]        send_data;
   logic [NREGS*8-1:0] regs_flat;
   logic               wr_stb;
   logic [3:0]         wr_addr;
   logic               busy;
   logic [ERR_W-1:0]   err_cnt;

   modport slave (
      input  recv_data, recv_rdy,
      output send_data, regs_flat, wr_stb, wr_addr, busy, err_cnt
   );

   modport master (
      output recv_data, recv_rdy,
      input  send_data, regs_flat, wr_stb, wr_addr, busy, err_cnt
   );

endinterface

// File: rtl/spi_slave_reg_ctrl_reg_bank.sv
// spi_reg_bank: NREGS x 8-bit register array with a single write port and a
// flat read bus (register i at bits [8*i+7:8*i]). Cleared by async reset.
module spi_reg_bank #(
   parameter int NREGS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wrEn,
   input  logic [3:0]         i_wrAddr,
   input  logic [7:0]         i_wrData,
   output logic [NREGS*8-1:0] o_regsFlat
);

   logic [7:0] r_regs [NREGS];

   // Write the addressed register when enabled; reset clears the whole bank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (i_wrEn && (i_wrAddr == 4'(i))) begin
               r_regs[i] <= i_wrData;
            end
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign o_regsFlat[8*g +: 8] = r_regs[g];
   end

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: turns the spi_slave byte stream into register accesses.
// Each rising edge of recv_rdy is one byte event; the FSM decodes commands,
// writes the register bank and prepares the next send word for the master.
// Optional feature macro: SPI_REG_CTRL_TIMEOUT_EN (inter-byte timeout while busy).
module spi_slave_reg_ctrl
   import spi_slave_reg_ctrl_pkg::*;
#(
   parameter int          NREGS          = 8,
   parameter logic [11:0] IDLE_WORD      = 12'hF55,
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter int          ERR_W          = 8
) (
   input  logic               clk,
   input  logic               rst,
   spi_slave_reg_ctrl_if.slave bus
);

   if ((NREGS < 2) || (NREGS > 16) || ((NREGS & (NREGS - 1)) != 0) ||
       (TIMEOUT_CYCLES < 2)) begin : g_badParams
      $error("spi_slave_reg_ctrl: unsupported NREGS or TIMEOUT_CYCLES");
   end

   state_t             r_state;
   state_t             w_stateNext;
   logic               r_rdyQ;
   logic               w_byteEvent;
   logic [11:0]        r_sendData;
   logic [11:0]        w_sendNext;
   logic [3:0]         r_addr;
   logic [3:0]         w_addrNext;
   logic               r_wrStb;
   logic [3:0]         r_wrAddr;
   logic               w_wrEn;
   logic               w_errInc;
   logic [ERR_W-1:0]   r_errCnt;
   logic               w_timeout;
   logic [7:0]         w_rdByte;
   logic [NREGS*8-1:0] w_regsFlat;

   assign w_byteEvent = bus.recv_rdy && !r_rdyQ;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_toCnt;

   // Count idle cycles between bytes of a command; any byte or idle state restarts it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_toCnt <= '0;
      end else if (w_byteEvent || (r_state == ST_IDLE) || (r_toCnt == TO_LAST)) begin
         r_toCnt <= '0;
      end else begin
         r_toCnt <= r_toCnt + 1'b1;
      end
   end

   assign w_timeout = (r_state != ST_IDLE) && !w_byteEvent && (r_toCnt == TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   // Select the register named by the incoming read command
   always_comb begin
      w_rdByte = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (bus.recv_data[CMD_ADDR_MSB:CMD_ADDR_LSB] == 4'(i)) begin
            w_rdByte = w_regsFlat[8*i +: 8];
         end
      end
   end

   // Decode each byte event against the current state and form the next send word
   always_comb begin
      w_stateNext = r_state;
      w_sendNext  = r_sendData;
      w_addrNext  = r_addr;
      w_wrEn      = 1'b0;
      w_errInc    = 1'b0;
      if (w_byteEvent) begin
         case (r_state)
            ST_IDLE: begin
               if (!cmdIsValid(bus.recv_data, NREGS)) begin
                  w_stateNext = ST_RD_RESP;
                  w_sendNext  = {ACK_ERR, bus.recv_data};
                  w_errInc    = 1'b1;
               end else if (bus.recv_data[CMD_WR_BIT]) begin
                  w_stateNext = ST_WR_DATA;
                  w_addrNext  = bus.recv_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
               end else begin
                  w_stateNext = ST_RD_RESP;
                  w_sendNext  = {ACK_OK, w_rdByte};
               end
            end
            ST_WR_DATA: begin
               w_stateNext = ST_IDLE;
               w_wrEn      = 1'b1;
               w_sendNext  = {ACK_OK, bus.recv_data};
            end
            ST_RD_RESP: begin
               w_stateNext = ST_IDLE;
               w_sendNext  = IDLE_WORD;
            end
            default: begin
               w_stateNext = ST_IDLE;
               w_sendNext  = IDLE_WORD;
            end
         endcase
      end else if (w_timeout) begin
         w_stateNext = ST_IDLE;
         w_sendNext  = IDLE_WORD;
         w_errInc    = 1'b1;
      end
   end

   // State, edge-detect history, latched write address and send word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_rdyQ     <= 1'b0;
         r_addr     <= '0;
         r_sendData <= IDLE_WORD;
      end else begin
         r_state    <= w_stateNext;
         r_rdyQ     <= bus.recv_rdy;
         r_addr     <= w_addrNext;
         r_sendData <= w_sendNext;
      end
   end

   // One-cycle write strobe with the address it applies to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrStb  <= 1'b0;
         r_wrAddr <= '0;
      end else begin
         r_wrStb <= w_wrEn;
         if (w_wrEn) begin
            r_wrAddr <= r_addr;
         end
      end
   end

   // Error counter sticks at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_errCnt <= '0;
      end else if (w_errInc && (r_errCnt != '1)) begin
         r_errCnt <= r_errCnt + 1'b1;
      end
   end

   spi_reg_bank #(
      .NREGS (NREGS)
   ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_wrEn     (w_wrEn),
      .i_wrAddr   (r_addr),
      .i_wrData   (bus.recv_data),
      .o_regsFlat (w_regsFlat)
   );

   assign bus.send_data = r_sendData;
   assign bus.regs_flat = w_regsFlat;
   assign bus.wr_stb    = r_wrStb;
   assign bus.wr_addr   = r_wrAddr;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.err_cnt   = r_errCnt;

endmodule
